// File: rtl/sensor_requester.sv
// Host-side requester for the sensor serial link: wake/ack handshake,
// address + command transmit, then a fixed 4-byte reply collected and judged.
//
// Ports:
//   clk_9600hz   single 9600 Hz clock
//   reset        asynchronous, active-high
//   req          start a transaction (sampled only in IDLE)
//   req_address  sensor address, captured on accepted req
//   req_command  sensor command, captured on accepted req
//   tx_data      byte for the UART transmitter (valid with tx_start)
//   tx_start     one-cycle transmit strobe
//   tx_busy      UART transmitter busy
//   rx_data      byte from the UART receiver
//   rx_received  one-cycle strobe, rx_data valid
//   busy         high from accepted req through the done pulse
//   done         one-cycle pulse at the end of every transaction
//   result       {data MSB, data LSB} from the last full frame
//   result_code  code byte from the last full frame
//   status       0 OK, 1 BAD_ACK, 2 SENSOR_ERR, 3 BAD_CODE, 4 BAD_END, 5 TIMEOUT

module sensor_requester #(
    parameter int          TIMEOUT_CYCLES = 2400,
    parameter logic [7:0]  END_BYTE       = 8'hF0
) (
    input  logic        clk_9600hz,
    input  logic        reset,
    input  logic        req,
    input  logic [7:0]  req_address,
    input  logic [7:0]  req_command,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_received,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  result_code,
    output logic [2:0]  status
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_BAD_ACK = 3'd1;
    localparam logic [2:0] ST_SNS_ERR = 3'd2;
    localparam logic [2:0] ST_BAD_CODE = 3'd3;
    localparam logic [2:0] ST_BAD_END = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    localparam logic [7:0] WAKE_BYTE = 8'h00;
    localparam logic [7:0] ACK_BYTE  = 8'h01;
    localparam logic [7:0] ERR_CODE  = 8'h0F;

    typedef enum logic [3:0] {
        IDLE,
        SEND_INIT,
        WAIT_ACK,
        SEND_ADDR,
        SEND_CMD,
        WAIT_CODE,
        WAIT_B1,
        WAIT_B2,
        WAIT_END,
        DONE
    } state_t;

    state_t        state;
    logic [7:0]    addr_q;
    logic [7:0]    cmd_q;
    logic [7:0]    code_q;
    logic [7:0]    b1_q;
    logic [7:0]    b2_q;
    logic [TW-1:0] timer;
    // 0: wait for idle tx and strobe, 1: strobe cycle (tx_busy stale),
    // 2: wait for the transmitter to finish
    logic [1:0]    tx_phase;

    logic [7:0]    send_byte;
    state_t        send_next;
    logic [7:0]    exp_code;
    logic [2:0]    end_status;
    logic          limit_hit;

    always_comb begin
        send_byte = WAKE_BYTE;
        send_next = WAIT_ACK;
        case (state)
            SEND_ADDR: begin
                send_byte = addr_q;
                send_next = SEND_CMD;
            end
            SEND_CMD: begin
                send_byte = cmd_q;
                send_next = WAIT_CODE;
            end
            default: begin
                send_byte = WAKE_BYTE;
                send_next = WAIT_ACK;
            end
        endcase
    end

    always_comb begin
        exp_code = 8'h00;
        if (cmd_q == 8'h04)
            exp_code = 8'h02;
        else if (cmd_q == 8'h05)
            exp_code = 8'h01;
    end

    // A bad terminator outranks any complaint about the code byte.
    always_comb begin
        end_status = ST_OK;
        if (rx_data != END_BYTE)
            end_status = ST_BAD_END;
        else if (code_q == ERR_CODE)
            end_status = ST_SNS_ERR;
        else if (code_q != exp_code)
            end_status = ST_BAD_CODE;
    end

    assign limit_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_9600hz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            cmd_q       <= '0;
            code_q      <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            timer       <= '0;
            tx_phase    <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_code <= '0;
            status      <= ST_OK;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q   <= req_address;
                        cmd_q    <= req_command;
                        busy     <= 1'b1;
                        status   <= ST_OK;
                        tx_phase <= 2'd0;
                        state    <= SEND_INIT;
                    end
                end

                SEND_INIT, SEND_ADDR, SEND_CMD: begin
                    case (tx_phase)
                        2'd0: begin
                            if (!tx_busy) begin
                                tx_start <= 1'b1;
                                tx_data  <= send_byte;
                                tx_phase <= 2'd1;
                            end
                        end
                        2'd1: tx_phase <= 2'd2;
                        default: begin
                            if (!tx_busy) begin
                                tx_phase <= 2'd0;
                                timer    <= '0;
                                state    <= send_next;
                            end
                        end
                    endcase
                end

                WAIT_ACK, WAIT_CODE, WAIT_B1, WAIT_B2, WAIT_END: begin
                    if (rx_received) begin
                        timer <= '0;
                        case (state)
                            WAIT_ACK: begin
                                if (rx_data == ACK_BYTE) begin
                                    state <= SEND_ADDR;
                                end else begin
                                    status <= ST_BAD_ACK;
                                    done   <= 1'b1;
                                    state  <= DONE;
                                end
                            end
                            WAIT_CODE: begin
                                code_q <= rx_data;
                                state  <= WAIT_B1;
                            end
                            WAIT_B1: begin
                                b1_q  <= rx_data;
                                state <= WAIT_B2;
                            end
                            WAIT_B2: begin
                                b2_q  <= rx_data;
                                state <= WAIT_END;
                            end
                            default: begin
                                result      <= {b1_q, b2_q};
                                result_code <= code_q;
                                status      <= end_status;
                                done        <= 1'b1;
                                state       <= DONE;
                            end
                        endcase
                    end else if (limit_hit) begin
                        status <= ST_TIMEOUT;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_requester.sv
// Directed bench for sensor_requester: scripted UART tx/rx byte engines,
// hand-computed frames and expected result/status per transaction.

module tb_sensor_requester;

    localparam int T = 2400;

    logic        clk;
    logic        reset;
    logic        req;
    logic [7:0]  req_address;
    logic [7:0]  req_command;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_received;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  result_code;
    logic [2:0]  status;

    int          total;
    int          bad;
    int          done_cnt;
    logic        tx_active;
    logic [7:0]  tx_q[$];

    sensor_requester #(
        .TIMEOUT_CYCLES(T),
        .END_BYTE(8'hF0)
    ) dut (
        .clk_9600hz (clk),
        .reset      (reset),
        .req        (req),
        .req_address(req_address),
        .req_command(req_command),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .rx_data    (rx_data),
        .rx_received(rx_received),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_code(result_code),
        .status     (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // UART transmitter model: busy for 3 edges starting the cycle after tx_start
    initial begin
        tx_busy   = 1'b0;
        tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                tx_q.push_back(tx_data);
                tx_active = 1'b1;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 tx_busy = 1'b0;
                tx_active = 1'b0;
            end
        end
    end

    initial begin
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    end

    task automatic wait_tx(input int n);
        int k;
        k = 0;
        while (!(tx_q.size() >= n && !tx_active) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tx_wait", k < 200, 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_received = 1'b1;
        @(posedge clk);
        #1 rx_received = 1'b0;
    endtask

    task automatic pulse_req(input logic [7:0] a, input logic [7:0] c);
        @(posedge clk);
        #1 req_address = a;
        req_command = c;
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    // dly < 0: never send the reply; otherwise edges to wait before the code byte
    task automatic serve(input logic [7:0] a, input logic [7:0] c,
                         input logic [7:0] ack, input logic [7:0] rc,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] e, input int dly,
                         input logic poke, input logic [2:0] est,
                         input logic [15:0] eres, input logic [7:0] ecode);
        int n;
        int d0;
        tx_q.delete();
        d0 = done_cnt;
        wait_tx(1);
        if (poke) begin
            req_address = 8'h77;
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            req_address = a;
        end
        send_rx(ack);
        if (ack == 8'h01) begin
            wait_tx(3);
            if (dly >= 0) begin
                repeat (dly) @(posedge clk);
                send_rx(rc);
                send_rx(b1);
                send_rx(b2);
                send_rx(e);
            end
        end
        n = 0;
        while (!done && n < T + 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("done_seen", done, 1);
        if (dly < 0) chk("to_cycles", n, T + 1);
        chk("status", status, est);
        chk("result", result, eres);
        chk("code", result_code, ecode);
        chk("busy_in_done", busy, 1);
        if (ack == 8'h01) begin
            chk("tx_n", tx_q.size(), 3);
            chk("tx0", tx_q[0], 8'h00);
            chk("tx1", tx_q[1], a);
            chk("tx2", tx_q[2], c);
        end else begin
            chk("tx_n", tx_q.size(), 1);
            chk("tx0", tx_q[0], 8'h00);
        end
        @(posedge clk);
        #1;
        chk("done_pulse", done, 0);
        chk("busy_off", busy, 0);
        chk("done_cnt", done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        total = 0;
        bad = 0;
        reset = 1'b1;
        req = 1'b0;
        req_address = 8'h00;
        req_command = 8'h00;
        rx_data = 8'h00;
        rx_received = 1'b0;
        #1;
        chk("rst_outs",
            {busy, done, tx_start, status, result_code, result, tx_data}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        pulse_req(8'h12, 8'h04);
        serve(8'h12, 8'h04, 8'h01, 8'h02, 8'h01, 8'h2C, 8'hF0,
              0, 1'b0, 3'd0, 16'h012C, 8'h02);

        @(posedge clk);
        #1 req_address = 8'h34;
        req_command = 8'h05;
        req = 1'b1;
        serve(8'h34, 8'h05, 8'h01, 8'h01, 8'h02, 8'h58, 8'hF0,
              0, 1'b0, 3'd0, 16'h0258, 8'h01);
        @(posedge clk);
        #1 chk("retrigger", busy, 1);
        req = 1'b0;
        serve(8'h34, 8'h05, 8'h01, 8'h01, 8'h03, 8'hE8, 8'hF0,
              0, 1'b0, 3'd0, 16'h03E8, 8'h01);

        pulse_req(8'h12, 8'h04);
        serve(8'h12, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00,
              0, 1'b0, 3'd1, 16'h03E8, 8'h01);

        pulse_req(8'h12, 8'h06);
        serve(8'h12, 8'h06, 8'h01, 8'h0F, 8'h00, 8'h00, 8'hF0,
              0, 1'b0, 3'd2, 16'h0000, 8'h0F);
        pulse_req(8'h12, 8'h04);
        serve(8'h12, 8'h04, 8'h01, 8'h01, 8'h11, 8'h22, 8'hF0,
              0, 1'b0, 3'd3, 16'h1122, 8'h01);
        pulse_req(8'h12, 8'h04);
        serve(8'h12, 8'h04, 8'h01, 8'h0F, 8'h33, 8'h44, 8'hAA,
              0, 1'b0, 3'd4, 16'h3344, 8'h0F);
        pulse_req(8'h12, 8'h06);
        serve(8'h12, 8'h06, 8'h01, 8'h00, 8'h55, 8'h66, 8'hF0,
              0, 1'b0, 3'd0, 16'h5566, 8'h00);

        pulse_req(8'h12, 8'h04);
        serve(8'h12, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
              -1, 1'b0, 3'd5, 16'h5566, 8'h00);
        pulse_req(8'h12, 8'h05);
        serve(8'h12, 8'h05, 8'h01, 8'h01, 8'h77, 8'h88, 8'hF0,
              T - 1, 1'b0, 3'd0, 16'h7788, 8'h01);

        pulse_req(8'h12, 8'h04);
        tx_q.delete();
        wait_tx(1);
        send_rx(8'h01);
        wait_tx(3);
        send_rx(8'h02);
        d0 = done_cnt;
        chk("busy_pre_rst", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async",
            {busy, done, tx_start, status, result_code, result, tx_data}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_no_done", done_cnt, d0);
        chk("rst_idle", busy, 0);

        pulse_req(8'h21, 8'h05);
        serve(8'h21, 8'h05, 8'h01, 8'h01, 8'hAB, 8'hCD, 8'hF0,
              0, 1'b1, 3'd0, 16'hABCD, 8'h01);
        repeat (3) @(negedge clk);
        chk("no_poke_retrig", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
